// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch
// Description : Stretches each sampled EV cycle into a HIGH_CYC-cycle OUT
//               pulse followed by at least LOW_CYC low cycles. Events that
//               arrive while a pulse is in flight are queued in a saturating
//               counter (PEND) and replayed back-to-back.
//               Optional macro PULSE_STRETCH_OVF_EN adds a sticky OVF flag
//               that records any event dropped because PEND was saturated.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretch #(
   parameter int HIGH_CYC = 4,
   parameter int LOW_CYC  = 4,
   parameter int CNT_W    = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EV,
   output logic             OUT,
   output logic             BUSY,
   output logic [CNT_W-1:0] PEND
`ifdef PULSE_STRETCH_OVF_EN
   ,
   output logic             OVF
`endif
);

   // Down-counter only ever holds (max phase length - 1)
   localparam int MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
   localparam int CTR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CTR_W-1:0] c_HIGH_LOAD = CTR_W'(HIGH_CYC - 1);
   localparam logic [CTR_W-1:0] c_LOW_LOAD  = CTR_W'(LOW_CYC - 1);
   localparam logic [CNT_W-1:0] c_PEND_MAX  = {CNT_W{1'b1}};

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_HIGH = 2'd1;
   localparam logic [1:0] c_LOW  = 2'd2;

   logic [1:0]       r_state;
   logic [CTR_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_pend;
   logic             r_out;
   logic             r_busy;

   logic [1:0]       w_state_nxt;
   logic [CTR_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_pend_nxt;
   logic             w_out_nxt;
   logic             w_busy_nxt;
   logic [CNT_W:0]   w_e;
   logic [CNT_W:0]   w_e_dec;

   // Events available at the final LOW cycle: queue plus the one arriving now.
   // One bit wider than PEND so a saturated queue plus EV does not wrap.
   assign w_e     = {1'b0, r_pend} + {{CNT_W{1'b0}}, EV};
   assign w_e_dec = w_e - {{CNT_W{1'b0}}, 1'b1};

   // State register with registered outputs; EV is irrelevant while in reset
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state <= c_IDLE;
         r_cnt   <= '0;
         r_pend  <= '0;
         r_out   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
         r_out   <= w_out_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Next-state, counter and pending-queue logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      case (r_state)
         c_IDLE: begin
            // Event in IDLE starts a pulse directly; PEND is untouched
            if (EV) begin
               w_state_nxt = c_HIGH;
               w_cnt_nxt   = c_HIGH_LOAD;
            end
         end
         c_HIGH: begin
            if (r_cnt == '0) begin
               w_state_nxt = c_LOW;
               w_cnt_nxt   = c_LOW_LOAD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
            if (EV && (r_pend != c_PEND_MAX)) begin
               w_pend_nxt = r_pend + 1'b1;
            end
         end
         c_LOW: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
               if (EV && (r_pend != c_PEND_MAX)) begin
                  w_pend_nxt = r_pend + 1'b1;
               end
            end else if (w_e != '0) begin
               // Final LOW cycle consumes one event (queued or current)
               w_state_nxt = c_HIGH;
               w_cnt_nxt   = c_HIGH_LOAD;
               w_pend_nxt  = w_e_dec[CNT_W-1:0];
            end else begin
               w_state_nxt = c_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
            w_pend_nxt  = '0;
         end
      endcase
   end

   // Output decode from the next state so OUT/BUSY come straight from flops
   always_comb begin
      w_out_nxt  = (w_state_nxt == c_HIGH);
      w_busy_nxt = (w_state_nxt != c_IDLE);
   end

   assign OUT  = r_out;
   assign BUSY = r_busy;
   assign PEND = r_pend;

`ifdef PULSE_STRETCH_OVF_EN
   logic r_ovf;
   logic w_drop;

   // An event is lost only in a non-consuming cycle with the queue full
   assign w_drop = EV && (r_pend == c_PEND_MAX) &&
                   ((r_state == c_HIGH) || ((r_state == c_LOW) && (r_cnt != '0)));

   // Sticky overflow flag, cleared only by reset
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end
   end

   assign OVF = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pulse_stretch
// Description : Scoreboard bench for pulse_stretch at default parameters.
//               Builds with or without PULSE_STRETCH_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretch;

   logic       CLK;
   logic       RESET;
   logic       EV;
   logic       OUT;
   logic       BUSY;
   logic [3:0] PEND;
   logic       w_ovf;

`ifdef PULSE_STRETCH_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
   assign w_ovf = 1'b0;
`endif

   typedef struct packed {
      logic       out;
      logic       busy;
      logic [3:0] pend;
      logic       ovf;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   pulse_stretch #(
      .HIGH_CYC (4),
      .LOW_CYC  (4),
      .CNT_W    (4)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .EV    (EV),
      .OUT   (OUT),
      .BUSY  (BUSY),
`ifdef PULSE_STRETCH_OVF_EN
      .PEND  (PEND),
      .OVF   (w_ovf)
`else
      .PEND  (PEND)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Drive one cycle of inputs and land 1ns after the sampling edge
   task automatic tick(input logic ev, input logic rstn);
      EV    = ev;
      RESET = rstn;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset(input string tag);
      exp_t e;
      for (int c = 0; c < 2; c++) begin
         q.push_back('{out: 1'b0, busy: 1'b0, pend: 4'd0, ovf: 1'b0});
         tick(1'b1, 1'b0);
         e = q.pop_front();
         checks++;
         if ({OUT, BUSY, PEND, w_ovf} !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d out/busy/pend/ovf got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                     tag, c, OUT, BUSY, PEND, w_ovf, e.out, e.busy, e.pend, e.ovf);
         end
      end
   endtask

   task automatic test_single;
      exp_t e;
      int   k;
      for (int c = 0; c < 12; c++) begin
         k = c + 1;
         q.push_back('{out: (k >= 1 && k <= 4), busy: (k >= 1 && k <= 8), pend: 4'd0, ovf: 1'b0});
         tick(c == 0, 1'b1);
         e = q.pop_front();
         checks++;
         if ({OUT, BUSY, PEND, w_ovf} !== e) begin
            errors++;
            $display("FAIL single cyc=%0d out/busy/pend/ovf got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                     k, OUT, BUSY, PEND, w_ovf, e.out, e.busy, e.pend, e.ovf);
         end
      end
   endtask

   task automatic test_queued;
      exp_t       e;
      int         k;
      logic [3:0] p;
      for (int c = 0; c < 27; c++) begin
         k = c + 1;
         if (k == 2)                p = 4'd1;
         else if (k >= 3 && k <= 8) p = 4'd2;
         else if (k >= 9 && k <= 16) p = 4'd1;
         else                       p = 4'd0;
         q.push_back('{out: ((k >= 1 && k <= 4) || (k >= 9 && k <= 12) || (k >= 17 && k <= 20)),
                       busy: (k >= 1 && k <= 24), pend: p, ovf: 1'b0});
         tick(c <= 2, 1'b1);
         e = q.pop_front();
         checks++;
         if ({OUT, BUSY, PEND, w_ovf} !== e) begin
            errors++;
            $display("FAIL queued cyc=%0d out/busy/pend/ovf got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                     k, OUT, BUSY, PEND, w_ovf, e.out, e.busy, e.pend, e.ovf);
         end
      end
   endtask

   task automatic test_saturate;
      exp_t       e;
      int         k;
      logic [3:0] p;
      for (int c = 0; c < 26; c++) begin
         k = c + 1;
         if (k <= 8)       p = 4'(k - 1);
         else if (k <= 16) p = 4'(k - 2);
         else if (k == 17) p = 4'd14;
         else if (k <= 24) p = 4'd15;
         else              p = 4'd14;
         q.push_back('{out: (((k - 1) % 8) < 4), busy: 1'b1, pend: p,
                       ovf: (OVF_ON && k >= 19)});
         tick(c <= 23, 1'b1);
         e = q.pop_front();
         checks++;
         if ({OUT, BUSY, PEND, w_ovf} !== e) begin
            errors++;
            $display("FAIL saturate cyc=%0d out/busy/pend/ovf got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                     k, OUT, BUSY, PEND, w_ovf, e.out, e.busy, e.pend, e.ovf);
         end
      end
   endtask

   task automatic test_reset_mid_pulse;
      exp_t e;
      int   k;
      for (int c = 0; c < 21; c++) begin
         k = c + 1;
         if (k == 1)      q.push_back('{out: 1'b1, busy: 1'b1, pend: 4'd0, ovf: 1'b0});
         else if (k == 2) q.push_back('{out: 1'b1, busy: 1'b1, pend: 4'd1, ovf: 1'b0});
         else             q.push_back('{out: 1'b0, busy: 1'b0, pend: 4'd0, ovf: 1'b0});
         tick(c <= 2, c != 2);
         e = q.pop_front();
         checks++;
         if ({OUT, BUSY, PEND, w_ovf} !== e) begin
            errors++;
            $display("FAIL reset_mid cyc=%0d out/busy/pend/ovf got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                     k, OUT, BUSY, PEND, w_ovf, e.out, e.busy, e.pend, e.ovf);
         end
      end
   endtask

   task automatic test_back_to_back;
      // Two events in consecutive IDLE/HIGH cycles: edges 8 cycles apart
      exp_t e;
      int   k;
      for (int c = 0; c < 18; c++) begin
         k = c + 1;
         q.push_back('{out: ((k >= 1 && k <= 4) || (k >= 9 && k <= 12)),
                       busy: (k >= 1 && k <= 16),
                       pend: (k >= 2 && k <= 8) ? 4'd1 : 4'd0, ovf: 1'b0});
         tick(c <= 1, 1'b1);
         e = q.pop_front();
         checks++;
         if ({OUT, BUSY, PEND, w_ovf} !== e) begin
            errors++;
            $display("FAIL back_to_back cyc=%0d out/busy/pend/ovf got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                     k, OUT, BUSY, PEND, w_ovf, e.out, e.busy, e.pend, e.ovf);
         end
      end
   endtask

   initial begin
      EV    = 1'b0;
      RESET = 1'b0;
      test_reset("reset_init");
      test_single();
      test_queued();
      test_back_to_back();
      test_saturate();
      test_reset("reset_busy");
      tick(1'b0, 1'b1);
      test_reset_mid_pulse();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
